// File: rtl/ks10_mem_resp.sv
// KS10 memory-side bus responder: claims in-range memory requests, waits WAIT_STATES cycles,
// accesses an internal RAM and pulses ACK. Optional KS10_MEMRESP_RMW_EN makes READ|WRITE a read-modify-write.
module ks10_mem_resp #(
    parameter int          ADDR_WIDTH  = 15,
    parameter int          WAIT_STATES = 2,
    parameter logic [19:0] BASE_ADDR   = 20'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busREQI,
    input  logic [35:0] busADDRI,
    input  logic [35:0] busDATAI,
    output logic        busACKO,
    output logic [35:0] busDATAO,
    output logic        memBUSY
);
    // KS10 numbers bits 0 (MSB) .. 35 (LSB); bus bit k lives at vector index 35-k.
    localparam int RD_B  = 35 - 3;
    localparam int WRT_B = 35 - 4;
    localparam int WR_B  = 35 - 5;
    localparam int IO_B  = 35 - 10;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACCESS, S_RMWWR, S_ACK, S_RECOVER
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   off_q;
    logic                    rd_q, wr_q, wrtest_q;
    logic [35:0]             data_q;
    logic [35:0]             rdata_q;
    logic [35:0]             mem [2**ADDR_WIDTH];

    logic [22:0] diff;
    logic        in_range, claim, mem_we, ret_rd;

    // Sign bit of the 23-bit difference flags addr < base; high bits flag addr >= base + size.
    assign diff     = {1'b0, busADDRI[21:0]} - {3'b000, BASE_ADDR};
    assign in_range = ~diff[22] && ((diff[21:0] >> ADDR_WIDTH) == 22'd0);
    assign claim    = busREQI && !busADDRI[IO_B] && (busADDRI[RD_B] || busADDRI[WR_B]) && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (claim) begin
                state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                cnt_d   = WS_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef KS10_MEMRESP_RMW_EN
            S_ACCESS:  state_d = (rd_q && wr_q) ? S_RMWWR : S_ACK;
`else
            S_ACCESS:  state_d = S_ACK;
`endif
            S_RMWWR:   state_d = S_ACK;
            S_ACK:     state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            off_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wrtest_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && claim) begin
                off_q    <= diff[ADDR_WIDTH-1:0];
                rd_q     <= busADDRI[RD_B];
                wr_q     <= busADDRI[WR_B];
                wrtest_q <= busADDRI[WRT_B];
                data_q   <= busDATAI;
            end
        end
    end

`ifdef KS10_MEMRESP_RMW_EN
    assign mem_we = (state_q == S_ACCESS && wr_q && !rd_q) || (state_q == S_RMWWR && wr_q && rd_q);
    assign ret_rd = rd_q;
`else
    // READ|WRITE degenerates to a plain write with no returned data.
    assign mem_we = (state_q == S_ACCESS) && wr_q;
    assign ret_rd = rd_q && !wr_q;
`endif

    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS) rdata_q <= mem[off_q];
        if (mem_we)              mem[off_q] <= data_q;
    end

    assign busACKO  = (state_q == S_ACK);
    assign busDATAO = (state_q == S_ACK && ret_rd) ? rdata_q : 36'd0;
    assign memBUSY  = (state_q != S_IDLE);

    // WRTEST is held for the pager; other flag bits are not decoded here.
    logic unused_bits;
    assign unused_bits = ^{busADDRI[35:33], busADDRI[29:26], busADDRI[24:22], wrtest_q};
endmodule

// File: tb/tb_ks10_mem_resp.sv
// Self-checking bench for ks10_mem_resp: directed scenarios plus a randomized mix against a memory model.
module tb_ks10_mem_resp;
    localparam int AW = 15;
    localparam int WS = 2;
`ifdef KS10_MEMRESP_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [35:0] addr, wdata;
    logic        ack, busy;
    logic [35:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [35:0] model [int];

    ks10_mem_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .BASE_ADDR(20'd0)) dut (
        .clk(clk), .rst(rst), .busREQI(req), .busADDRI(addr), .busDATAI(wdata),
        .busACKO(ack), .busDATAO(rdata), .memBUSY(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input logic [21:0] a, input bit rd, input bit wr,
                                       input bit io, input bit wrt);
        logic [35:0] w;
        w = 36'd0;
        w[21:0] = a;
        w[32] = rd;
        w[31] = wrt;
        w[30] = wr;
        w[25] = io;
        return w;
    endfunction

    // Drives one request and reports what the bus showed; lat=-1 when no ACK within limit.
    task automatic run_txn(input logic [35:0] aw, input logic [35:0] d, input int drop, input int limit,
                           output int lat, output logic [35:0] dout, output logic ack_rec,
                           output logic [35:0] dout_rec, output int busy_cnt, output logic busy_end);
        @(negedge clk);
        req = 1'b1; addr = aw; wdata = d;
        lat = -1; dout = '0; ack_rec = 1'b0; dout_rec = '0; busy_cnt = 0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (drop > 0 && n == drop) begin
                req = 1'b0; addr = 36'({$urandom, $urandom}); wdata = 36'({$urandom, $urandom});
            end
            if (busy) busy_cnt++;
            if (ack) begin
                lat = n; dout = rdata;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            ack_rec = ack; dout_rec = rdata;
            if (busy) busy_cnt++;
        end
        req = 1'b0;
        @(negedge clk);
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ack !== 1'b0 || rdata !== 36'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ack=%b data=%o busy=%b, want 0/0/0", ack, rdata, busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, bc; logic [35:0] d, dr; logic ar, be;
        run_txn(mk(22'o100, 0, 1, 0, 0), 36'o123456701234, 0, 20, lat, d, ar, dr, bc, be);
        model[22'o100] = 36'o123456701234;
        n_tests++;
        if (lat !== WS + 2 || d !== 36'd0) begin
            n_fail++; $display("FAIL write: lat=%0d data=%o, want %0d/0", lat, d, WS + 2);
        end
        n_tests++;
        if (bc !== WS + 3 || be !== 1'b0) begin
            n_fail++; $display("FAIL write_busy: busy cycles=%0d end=%b, want %0d/0", bc, be, WS + 3);
        end
        run_txn(mk(22'o100, 1, 0, 0, 0), 36'd0, 0, 20, lat, d, ar, dr, bc, be);
        n_tests++;
        if (lat !== WS + 2 || d !== 36'o123456701234) begin
            n_fail++; $display("FAIL read: lat=%0d data=%o, want %0d/%o", lat, d, WS + 2, 36'o123456701234);
        end
        n_tests++;
        if (ar !== 1'b0 || dr !== 36'd0) begin
            n_fail++; $display("FAIL read_after_ack: ack=%b data=%o, want 0/0", ar, dr);
        end
    endtask

    task automatic test_unclaimed();
        int lat, bc; logic [35:0] d, dr; logic ar, be;
        run_txn(mk(22'o100, 1, 0, 1, 0), 36'd0, 0, 50, lat, d, ar, dr, bc, be);
        n_tests++;
        if (lat !== -1 || bc !== 0) begin
            n_fail++; $display("FAIL io_unclaimed: lat=%0d busy cycles=%0d, want -1/0", lat, bc);
        end
        run_txn(mk(22'(1 << AW), 1, 0, 0, 0), 36'd0, 0, 50, lat, d, ar, dr, bc, be);
        n_tests++;
        if (lat !== -1 || bc !== 0) begin
            n_fail++; $display("FAIL range_unclaimed: lat=%0d busy cycles=%0d, want -1/0", lat, bc);
        end
    endtask

    task automatic test_drop_early();
        int lat, bc; logic [35:0] d, dr; logic ar, be;
        run_txn(mk(22'o400, 0, 1, 0, 0), 36'o765432101234, 1, 20, lat, d, ar, dr, bc, be);
        model[22'o400] = 36'o765432101234;
        n_tests++;
        if (lat !== WS + 2) begin
            n_fail++; $display("FAIL drop_ack: lat=%0d, want %0d", lat, WS + 2);
        end
        run_txn(mk(22'o400, 1, 0, 0, 0), 36'd0, 0, 20, lat, d, ar, dr, bc, be);
        n_tests++;
        if (d !== model[22'o400]) begin
            n_fail++; $display("FAIL drop_data: got %o, want %o", d, model[22'o400]);
        end
    endtask

    task automatic test_back_to_back();
        int acks[$]; int want_n;
        @(negedge clk);
        req = 1'b1; addr = mk(22'o100, 1, 0, 0, 0); wdata = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ack) acks.push_back(n);
        end
        req = 1'b0;
        repeat (8) @(negedge clk);
        want_n = 0;
        for (int k = 0; (WS + 2) + k * (WS + 4) <= 30; k++) want_n++;
        n_tests++;
        if (acks.size() != want_n) begin
            n_fail++; $display("FAIL b2b_count: got %0d acks, want %0d", acks.size(), want_n);
        end
        for (int k = 0; k < acks.size() && k < want_n; k++) begin
            n_tests++;
            if (acks[k] != (WS + 2) + k * (WS + 4)) begin
                n_fail++; $display("FAIL b2b_time[%0d]: got %0d, want %0d", k, acks[k], (WS + 2) + k * (WS + 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [35:0] d, dr; logic ar, be;
        run_txn(mk(22'o200, 0, 1, 0, 0), 36'o111, 0, 20, lat, d, ar, dr, bc, be);
        model[22'o200] = 36'o111;
        @(negedge clk);
        req = 1'b1; addr = mk(22'o200, 0, 1, 0, 0); wdata = 36'o222;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: ack=%b busy=%b, want 0/0", ack, busy);
        end
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_txn(mk(22'o200, 1, 0, 0, 0), 36'd0, 0, 20, lat, d, ar, dr, bc, be);
        n_tests++;
        if (d !== 36'o111) begin
            n_fail++; $display("FAIL reset_mid_data: got %o, want %o", d, 36'o111);
        end
    endtask

    task automatic test_rmw();
        int lat, bc; logic [35:0] d, dr; logic ar, be;
        run_txn(mk(22'o300, 0, 1, 0, 0), 36'o5, 0, 20, lat, d, ar, dr, bc, be);
        run_txn(mk(22'o300, 1, 1, 0, 0), 36'o7, 0, 20, lat, d, ar, dr, bc, be);
        model[22'o300] = 36'o7;
        n_tests++;
        if (lat !== (RMW_EN ? WS + 3 : WS + 2) || d !== (RMW_EN ? 36'o5 : 36'o0)) begin
            n_fail++; $display("FAIL rmw: lat=%0d data=%o, want %0d/%o", lat, d,
                               RMW_EN ? WS + 3 : WS + 2, RMW_EN ? 36'o5 : 36'o0);
        end
        run_txn(mk(22'o300, 1, 0, 0, 0), 36'd0, 0, 20, lat, d, ar, dr, bc, be);
        n_tests++;
        if (d !== 36'o7) begin
            n_fail++; $display("FAIL rmw_mem: got %o, want %o", d, 36'o7);
        end
    endtask

    task automatic test_random();
        logic [21:0] pool [8];
        int lat, bc, op, exp_lat; logic [35:0] d, dr, v, exp_d; logic ar, be;
        logic [21:0] a; bit rd, wr, io;
        pool[0] = 22'd0; pool[1] = 22'd1; pool[2] = 22'o777; pool[3] = 22'o12345;
        pool[4] = 22'((1 << AW) - 1); pool[5] = 22'o40000; pool[6] = 22'o1000; pool[7] = 22'o2;
        for (int i = 0; i < 8; i++) begin
            v = 36'({$urandom, $urandom});
            run_txn(mk(pool[i], 0, 1, 0, 0), v, 0, 20, lat, d, ar, dr, bc, be);
            model[pool[i]] = v;
        end
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 5);
            a = pool[$urandom_range(0, 7)];
            rd = (op == 0 || op == 2 || op == 3 || op == 4);
            wr = (op == 1 || op == 2);
            io = (op == 3);
            if (op == 4) a = 22'((1 << AW) + $urandom_range(0, 1000));
            v = 36'({$urandom, $urandom});
            run_txn(mk(a, rd, wr, io, 1'($urandom)), v, 0, (op >= 3) ? 12 : 20, lat, d, ar, dr, bc, be);
            if (op >= 3) begin
                exp_lat = -1; exp_d = 36'd0;
            end else begin
                exp_lat = WS + 2 + ((RMW_EN && rd && wr) ? 1 : 0);
                exp_d   = (rd && (!wr || RMW_EN)) ? model[a] : 36'd0;
                if (wr) model[a] = v;
            end
            n_tests++;
            if (lat !== exp_lat || d !== exp_d || (exp_lat > 0 && bc !== exp_lat + 1) || be !== 1'b0) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%0d a=%o: lat=%0d data=%o busy=%0d, want %0d/%o/%0d",
                         it, op, a, lat, d, bc, exp_lat, exp_d, exp_lat + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unclaimed();
        test_drop_early();
        test_back_to_back();
        test_reset_mid();
        test_rmw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
